// File: rtl/aes_pkg.sv
// Shared AES definitions: key-length encodings, round counts and GF(2^8) arithmetic.
// Used by both the encipher and decipher blocks.
package aes_pkg;

    localparam logic       KEYLEN_128 = 1'b0;
    localparam logic       KEYLEN_256 = 1'b1;
    localparam logic [3:0] ROUNDS_128 = 4'd10;
    localparam logic [3:0] ROUNDS_256 = 4'd14;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i])
                acc = acc ^ x;
            x = xtime(x);
        end
        return acc;
    endfunction

    function automatic logic [7:0] gf_mul9(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul11(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul13(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction

    function automatic logic [7:0] gf_mul14(input logic [7:0] b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] a2, a3, a12, a15, a240;
        a2   = gf_mul(a, a);
        a3   = gf_mul(a2, a);
        a12  = gf_mul(gf_mul(a3, a3), gf_mul(a3, a3));
        a15  = gf_mul(a12, a3);
        a240 = gf_mul(a15, a15);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        a240 = gf_mul(a240, a240);
        return gf_mul(gf_mul(a240, a12), a2);
    endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// Inverse S-box on one 32-bit word: four independent byte lookups, computed
// as inverse affine transform followed by GF(2^8) inversion.
module aes_inv_sbox
    import aes_pkg::*;
(
    input  logic [31:0] sword,
    output logic [31:0] new_sword
);

    function automatic logic [7:0] inv_sbox_byte(input logic [7:0] s);
        logic [7:0] b;
        b = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    for (genvar gi = 0; gi < 4; gi++) begin : g_byte
        assign new_sword[8*gi +: 8] = inv_sbox_byte(sword[8*gi +: 8]);
    end

endmodule

// File: rtl/aes_decipher_block.sv
// Iterative AES-128/256 decipher core: one full-state round step per MAIN/INIT
// cycle, with the inverse S-box applied one word per cycle through a single instance.
module aes_decipher_block
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    typedef enum logic [2:0] {ST_IDLE, ST_INIT, ST_SBOX, ST_MAIN, ST_FINAL} state_t;

    state_t       fsm_reg, fsm_next;
    logic [31:0]  word_reg  [4];
    logic [31:0]  word_next [4];
    logic [3:0]   round_ctr_reg, round_ctr_next;
    logic [1:0]   sword_ctr_reg, sword_ctr_next;
    logic         ready_reg, ready_next;
    logic [127:0] state_vec;
    logic [31:0]  sbox_in, sbox_out;

    // Byte r of column c sits at bits [127-8*(4c+r) -: 8]; row r rotates right by r.
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*((c + 4 - r) % 4) + r) -: 8];
        return res;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] res;
        logic [7:0]   a0, a1, a2, a3;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            res[127 - 32*c -: 8] = gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3);
            res[119 - 32*c -: 8] = gf_mul9(a0) ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3);
            res[111 - 32*c -: 8] = gf_mul13(a0) ^ gf_mul9(a1) ^ gf_mul14(a2) ^ gf_mul11(a3);
            res[103 - 32*c -: 8] = gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2) ^ gf_mul14(a3);
        end
        return res;
    endfunction

    assign state_vec = {word_reg[0], word_reg[1], word_reg[2], word_reg[3]};
    assign sbox_in   = word_reg[sword_ctr_reg];

    aes_inv_sbox u_inv_sbox (
        .sword     (sbox_in),
        .new_sword (sbox_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            fsm_reg <= ST_IDLE;
        else
            fsm_reg <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            ST_IDLE:  if (next) fsm_next = ST_INIT;
            ST_INIT:  fsm_next = ST_SBOX;
            ST_SBOX:  if (sword_ctr_reg == 2'd3)
                          fsm_next = (round_ctr_reg != 4'd0) ? ST_MAIN : ST_FINAL;
            ST_MAIN:  fsm_next = ST_SBOX;
            ST_FINAL: fsm_next = ST_IDLE;
            default:  fsm_next = ST_IDLE;
        endcase
    end

    always_comb begin
        logic [127:0] load_vec;
        logic         load;
        load           = 1'b0;
        load_vec       = state_vec;
        word_next      = word_reg;
        round_ctr_next = round_ctr_reg;
        sword_ctr_next = sword_ctr_reg;
        ready_next     = ready_reg;
        case (fsm_reg)
            ST_IDLE: begin
                if (next) begin
                    round_ctr_next = (keylen == KEYLEN_256) ? ROUNDS_256 : ROUNDS_128;
                    ready_next     = 1'b0;
                end
            end
            ST_INIT, ST_MAIN: begin
                load           = 1'b1;
                load_vec       = (fsm_reg == ST_INIT) ? inv_shift_rows(block ^ round_key)
                                 : inv_shift_rows(inv_mix_columns(state_vec ^ round_key));
                round_ctr_next = (round_ctr_reg != 4'd0) ? round_ctr_reg - 4'd1 : 4'd0;
                sword_ctr_next = 2'd0;
            end
            ST_SBOX: begin
                word_next[sword_ctr_reg] = sbox_out;
                sword_ctr_next           = sword_ctr_reg + 2'd1;
            end
            ST_FINAL: begin
                load       = 1'b1;
                load_vec   = state_vec ^ round_key;
                ready_next = 1'b1;
            end
            default: ;
        endcase
        if (load)
            for (int i = 0; i < 4; i++)
                word_next[i] = load_vec[127 - 32*i -: 32];
    end

    for (genvar gi = 0; gi < 4; gi++) begin : g_word
        always_ff @(posedge clk or posedge reset) begin
            if (reset)
                word_reg[gi] <= '0;
            else
                word_reg[gi] <= word_next[gi];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            round_ctr_reg <= '0;
            sword_ctr_reg <= '0;
            ready_reg     <= 1'b1;
        end else begin
            round_ctr_reg <= round_ctr_next;
            sword_ctr_reg <= sword_ctr_next;
            ready_reg     <= ready_next;
        end
    end

    assign round     = round_ctr_reg;
    assign new_block = state_vec;
    assign ready     = ready_reg;

endmodule

// File: tb/tb_aes_decipher_block.sv
// Self-checking bench for aes_decipher_block using FIPS-197 vectors and a
// round-key memory expanded by the bench's own key schedule.
module tb_aes_decipher_block;

    logic         clk = 1'b0;
    logic         reset, next, keylen;
    logic [3:0]   round;
    logic [127:0] round_key, block, new_block;
    logic         ready;

    typedef struct {
        logic [127:0] pt;
        int           lat;
    } exp_t;

    exp_t         sb_q [$];
    int           checks = 0;
    int           errors = 0;
    logic [7:0]   sbox_t   [256];
    logic [127:0] cur_keys [16];

    localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [255:0] KEY256 =
        256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

    always #5 clk = ~clk;

    assign round_key = cur_keys[round];

    aes_decipher_block dut (
        .clk       (clk),
        .reset     (reset),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    function automatic logic [7:0] m_xt(input logic [7:0] b);
        return b[7] ? ((b << 1) ^ 8'h1b) : (b << 1);
    endfunction

    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = m_xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    // Forward S-box by brute-force inverse search plus the forward affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            if (x != 0)
                for (int y = 1; y < 256; y++)
                    if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
    endfunction

    task automatic load_keys(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rcon = 8'h01;
        int          nr = nk + 6;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr + 1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = m_xt(rcon);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            cur_keys[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'h0;
    endtask

    // Drives next for one cycle's accept edge; returns 1 ns after that edge.
    task automatic start_run(input logic kl, input logic [127:0] ct, input int exp_lat);
        exp_t e;
        @(negedge clk);
        next   = 1'b1;
        keylen = kl;
        block  = ct;
        e.pt   = PT;
        e.lat  = exp_lat;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Counts cycles to ready and logs the requested round index each busy cycle.
    task automatic wait_done(input int nr, input bit hold, input bit toggle,
                             output int lat, output int round_bad);
        int exp_r, rr;
        lat = 0;
        round_bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            exp_r = (i == 0) ? nr : nr - 1 - (i - 1) / 5;
            rr = int'(round);
            if (rr !== exp_r) round_bad++;
            if (toggle) begin
                if (i == 5 || i == 20 || i == 50) begin
                    next   = 1'b1;
                    keylen = ~keylen;
                end else begin
                    next = 1'b0;
                end
            end else if (!hold) begin
                next = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (ready) break;
        end
        if (!hold) next = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        next   = 1'b0;
        keylen = 1'b0;
        block  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", ready); end
        checks++; if (new_block !== 128'h0) begin errors++; $display("FAIL reset_block: got %h expected 0", new_block); end
        checks++; if (round !== 4'd0) begin errors++; $display("FAIL reset_round: got %0d expected 0", round); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL idle_hold_ready: got %b expected 1", ready); end
        $display("reset: ready=%b round=%0d new_block=%h", ready, round, new_block);
    endtask

    task automatic test_c1();
        exp_t e;
        int   lat, rb;
        load_keys(KEY128, 4);
        start_run(1'b0, CT128, 51);
        wait_done(10, 1'b0, 1'b0, lat, rb);
        e = sb_q.pop_front();
        checks++; if (new_block !== e.pt) begin errors++; $display("FAIL c1_value: got %h expected %h", new_block, e.pt); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL c1_latency: got %0d expected %0d", lat, e.lat); end
        checks++; if (rb !== 0) begin errors++; $display("FAIL c1_round_seq: got %0d bad cycles expected 0", rb); end
        $display("c1: latency=%0d new_block=%h", lat, new_block);
        repeat (5) @(negedge clk);
        checks++; if (new_block !== PT) begin errors++; $display("FAIL c1_hold: got %h expected %h", new_block, PT); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL c1_ready_hold: got %b expected 1", ready); end
    endtask

    task automatic test_c3();
        exp_t e;
        int   lat, rb;
        load_keys(KEY256, 8);
        start_run(1'b1, CT256, 71);
        wait_done(14, 1'b0, 1'b0, lat, rb);
        e = sb_q.pop_front();
        checks++; if (new_block !== e.pt) begin errors++; $display("FAIL c3_value: got %h expected %h", new_block, e.pt); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL c3_latency: got %0d expected %0d", lat, e.lat); end
        checks++; if (rb !== 0) begin errors++; $display("FAIL c3_round_seq: got %0d bad cycles expected 0", rb); end
        $display("c3: latency=%0d new_block=%h", lat, new_block);
    endtask

    task automatic test_busy_inputs();
        exp_t e;
        int   lat, rb;
        load_keys(KEY128, 4);
        start_run(1'b0, CT128, 51);
        wait_done(10, 1'b0, 1'b1, lat, rb);
        keylen = 1'b0;
        e = sb_q.pop_front();
        checks++; if (new_block !== e.pt) begin errors++; $display("FAIL busy_value: got %h expected %h", new_block, e.pt); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL busy_latency: got %0d expected %0d", lat, e.lat); end
        checks++; if (rb !== 0) begin errors++; $display("FAIL busy_round_seq: got %0d bad cycles expected 0", rb); end
        repeat (2) @(negedge clk);
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL busy_no_restart: got ready=%b expected 1", ready); end
        $display("busy_inputs: latency=%0d new_block=%h", lat, new_block);
    endtask

    task automatic test_reset_midrun();
        exp_t e;
        int   lat, rb;
        load_keys(KEY256, 8);
        start_run(1'b1, CT256, 71);
        @(negedge clk);
        next = 1'b0;
        repeat (29) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        void'(sb_q.pop_front());
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL abort_ready: got %b expected 1", ready); end
        checks++; if (new_block !== 128'h0) begin errors++; $display("FAIL abort_block: got %h expected 0", new_block); end
        checks++; if (round !== 4'd0) begin errors++; $display("FAIL abort_round: got %0d expected 0", round); end
        @(negedge clk);
        reset = 1'b0;
        load_keys(KEY128, 4);
        start_run(1'b0, CT128, 51);
        wait_done(10, 1'b0, 1'b0, lat, rb);
        e = sb_q.pop_front();
        checks++; if (new_block !== e.pt) begin errors++; $display("FAIL post_abort_value: got %h expected %h", new_block, e.pt); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL post_abort_latency: got %0d expected %0d", lat, e.lat); end
        checks++; if (rb !== 0) begin errors++; $display("FAIL post_abort_round_seq: got %0d bad cycles expected 0", rb); end
        $display("reset_midrun: latency=%0d new_block=%h", lat, new_block);
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   lat, rb;
        load_keys(KEY128, 4);
        start_run(1'b0, CT128, 51);
        wait_done(10, 1'b1, 1'b0, lat, rb);
        e = sb_q.pop_front();
        checks++; if (new_block !== e.pt) begin errors++; $display("FAIL b2b_first_value: got %h expected %h", new_block, e.pt); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL b2b_first_latency: got %0d expected %0d", lat, e.lat); end
        checks++; if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_pulse: got %b expected 1", ready); end
        $display("b2b run1: latency=%0d new_block=%h", lat, new_block);
        e.pt  = PT;
        e.lat = 51;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        checks++; if (ready !== 1'b0) begin errors++; $display("FAIL b2b_restart: got ready=%b expected 0", ready); end
        wait_done(10, 1'b0, 1'b0, lat, rb);
        e = sb_q.pop_front();
        checks++; if (new_block !== e.pt) begin errors++; $display("FAIL b2b_second_value: got %h expected %h", new_block, e.pt); end
        checks++; if (lat !== e.lat) begin errors++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, e.lat); end
        checks++; if (rb !== 0) begin errors++; $display("FAIL b2b_round_seq: got %0d bad cycles expected 0", rb); end
        $display("b2b run2: latency=%0d new_block=%h", lat, new_block);
    endtask

    initial begin
        build_sbox();
        for (int r = 0; r < 16; r++) cur_keys[r] = '0;
        test_reset();
        test_c1();
        test_c3();
        test_busy_inputs();
        test_reset_midrun();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
